// File: rtl/mem_dump.sv
// Purpose: dump a run of 32-bit BRAM words as a little-endian byte stream.
// Latency: start -> READ +1, LATCH +2, first tx_valid +3; 6 cycles/word at full rate.
// Backpressure: tx_ready low holds the current byte stable; the FSM waits in SEND.
module mem_dump #(
   parameter int ADDR_W = 10,
   parameter int CNT_W  = 9
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  word_count,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd_enb,
   input  logic [31:0]       mem_rd_dat,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic              busy,
   output logic              done
);

   typedef enum logic [2:0] {
      IDLE,
      READ,
      LATCH,
      SEND,
      FIN
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]  remain_q, remain_d;
   logic [31:0]       shift_q, shift_d;
   logic [1:0]        idx_q, idx_d;
   logic              xfer;

   // A byte leaves only while SEND presents it and the sink takes it.
   assign xfer = (state_q == SEND) && tx_ready;

   // Next-state, address/count bookkeeping and byte shifting.
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      remain_d = remain_q;
      shift_d  = shift_q;
      idx_d    = idx_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               // Word-align by masking the two low address bits.
               addr_d   = base_addr & ~ADDR_W'(3);
               remain_d = word_count;
               state_d  = (word_count == '0) ? FIN : READ;
            end
         end
         READ: begin
            state_d = LATCH;
         end
         LATCH: begin
            shift_d = mem_rd_dat;
            idx_d   = 2'd0;
            state_d = SEND;
         end
         SEND: begin
            if (xfer) begin
               shift_d = {8'h00, shift_q[31:8]};
               idx_d   = idx_q + 2'd1;
               if (idx_q == 2'd3) begin
                  // Wraps naturally at the top of the address space.
                  addr_d   = addr_q + ADDR_W'(4);
                  remain_d = remain_q - CNT_W'(1);
                  state_d  = (remain_q == CNT_W'(1)) ? FIN : READ;
               end
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset wins over everything, including start.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         remain_q <= '0;
         shift_q  <= '0;
         idx_q    <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         remain_q <= remain_d;
         shift_q  <= shift_d;
         idx_q    <= idx_d;
      end
   end

   assign mem_addr   = addr_q;
   assign mem_rd_enb = (state_q == READ);
   assign tx_data    = shift_q[7:0];
   assign tx_valid   = (state_q == SEND);
   assign busy       = (state_q != IDLE);
   assign done       = (state_q == FIN);

endmodule

// File: tb/tb_mem_dump.sv
// Scoreboard bench for mem_dump: stimulus queues expected reads, bytes and done
// latencies; a negedge monitor pops and compares whenever the DUT presents them.
module tb_mem_dump;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [9:0]  base_addr = '0;
   logic [8:0]  word_count = '0;
   logic [9:0]  mem_addr;
   logic        mem_rd_enb;
   logic [31:0] mem_rd_dat = '0;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b1;
   logic        busy;
   logic        done;

   int n_vec = 0;
   int n_bad = 0;
   int cyc = 0;
   int start_cyc = 0;

   logic [31:0] mem [0:255];

   logic [9:0] exp_addr[$];
   logic [7:0] exp_byte[$];
   int         exp_lat[$];

   logic       prev_stall = 1'b0;
   logic [7:0] prev_data = '0;

   mem_dump #(.ADDR_W(10), .CNT_W(9)) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .base_addr(base_addr),
      .word_count(word_count),
      .mem_addr(mem_addr),
      .mem_rd_enb(mem_rd_enb),
      .mem_rd_dat(mem_rd_dat),
      .tx_data(tx_data),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready),
      .busy(busy),
      .done(done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // BRAM model: data valid the cycle after the read enable.
   always @(posedge clk) begin
      if (mem_rd_enb) mem_rd_dat <= mem[mem_addr[9:2]];
   end

   // Monitor: compare everything the DUT presents against the scoreboard.
   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            n_vec++;
            if (!tx_valid || tx_data !== prev_data) begin
               n_bad++;
               $display("FAIL hold: valid=%0b data=%02h, required valid=1 data=%02h",
                        tx_valid, tx_data, prev_data);
            end
         end
         if (mem_rd_enb) begin
            n_vec++;
            if (exp_addr.size() == 0) begin
               n_bad++;
               $display("FAIL rd_addr: unexpected read at %03h, required none", mem_addr);
            end else begin
               logic [9:0] ea;
               ea = exp_addr.pop_front();
               if (mem_addr !== ea) begin
                  n_bad++;
                  $display("FAIL rd_addr: got %03h, required %03h", mem_addr, ea);
               end
            end
         end
         if (tx_valid && tx_ready) begin
            n_vec++;
            if (exp_byte.size() == 0) begin
               n_bad++;
               $display("FAIL tx_byte: unexpected byte %02h, required none", tx_data);
            end else begin
               logic [7:0] eb;
               eb = exp_byte.pop_front();
               if (tx_data !== eb) begin
                  n_bad++;
                  $display("FAIL tx_byte: got %02h, required %02h", tx_data, eb);
               end
            end
         end
         if (done) begin
            n_vec++;
            if (exp_lat.size() == 0) begin
               n_bad++;
               $display("FAIL done: unexpected pulse at cycle %0d, required none", cyc);
            end else begin
               int el;
               int lat;
               el = exp_lat.pop_front();
               // Rising edges from the one that samples start to the one that samples done.
               lat = cyc - start_cyc + 2;
               if (el >= 0 && lat != el) begin
                  n_bad++;
                  $display("FAIL done_lat: got %0d, required %0d", lat, el);
               end
            end
         end
         prev_stall = tx_valid && !tx_ready;
         prev_data  = tx_data;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic push_word(input logic [9:0] a, input logic [31:0] w);
      exp_addr.push_back(a);
      for (int k = 0; k < 4; k++) exp_byte.push_back(w[8*k +: 8]);
   endtask

   task automatic do_start(input logic [9:0] b, input logic [8:0] c);
      @(posedge clk);
      #1;
      start      = 1'b1;
      base_addr  = b;
      word_count = c;
      @(posedge clk);
      #1;
      start     = 1'b0;
      start_cyc = cyc;
   endtask

   // Run until the DUT is idle and the scoreboard is drained, within a cycle budget.
   task automatic wait_done(input bit rnd);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(posedge clk);
         #1;
         tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (!busy && exp_addr.size() == 0 && exp_byte.size() == 0 && exp_lat.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      tx_ready = 1'b1;
      n_vec++;
      if (!ok) begin
         n_bad++;
         $display("FAIL timeout: busy=%0b pending=%0d, required idle with 0 pending",
                  busy, exp_addr.size() + exp_byte.size() + exp_lat.size());
         exp_addr.delete();
         exp_byte.delete();
         exp_lat.delete();
      end
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_mem_addr"}, 32'(mem_addr), 32'h0);
      chk({tag, "_mem_rd_enb"}, 32'(mem_rd_enb), 32'h0);
      chk({tag, "_tx_data"}, 32'(tx_data), 32'h0);
      chk({tag, "_tx_valid"}, 32'(tx_valid), 32'h0);
      chk({tag, "_busy"}, 32'(busy), 32'h0);
      chk({tag, "_done"}, 32'(done), 32'h0);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[0]   = 32'h0000_0001;
      mem[1]   = 32'h0000_0002;
      mem[2]   = 32'h4433_2211;
      mem[3]   = 32'hFFFF_FFFF;
      mem[4]   = 32'hDEAD_BEEF;
      mem[255] = 32'hA1B2_C3D4;

      // Reset state.
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_outputs_zero("reset");
      rst = 1'b0;

      // Two words from 0x0 at full rate.
      push_word(10'h000, 32'h0000_0001);
      push_word(10'h004, 32'h0000_0002);
      exp_lat.push_back(14);
      do_start(10'h000, 9'd2);
      chk("busy_after_start", 32'(busy), 32'h1);
      wait_done(1'b0);

      // Zero-length dump: done only, no reads, no bytes.
      exp_lat.push_back(2);
      do_start(10'h000, 9'd0);
      wait_done(1'b0);

      // Unaligned base is rounded down to the word.
      push_word(10'h00C, 32'hFFFF_FFFF);
      exp_lat.push_back(8);
      do_start(10'h00E, 9'd1);
      wait_done(1'b0);

      // Random sink stalls: EF BE AD DE, each held until accepted.
      exp_addr.push_back(10'h010);
      exp_byte.push_back(8'hEF);
      exp_byte.push_back(8'hBE);
      exp_byte.push_back(8'hAD);
      exp_byte.push_back(8'hDE);
      exp_lat.push_back(-1);
      do_start(10'h010, 9'd1);
      wait_done(1'b1);

      // Address wrap from the top word back to zero.
      push_word(10'h3FC, 32'hA1B2_C3D4);
      push_word(10'h000, 32'h0000_0001);
      exp_lat.push_back(14);
      do_start(10'h3FC, 9'd2);
      wait_done(1'b0);

      // Reset on the same edge as start keeps the block idle.
      @(posedge clk);
      #1;
      rst        = 1'b1;
      start      = 1'b1;
      base_addr  = 10'h000;
      word_count = 9'd1;
      @(posedge clk);
      #1;
      rst   = 1'b0;
      start = 1'b0;
      chk("rst_start_busy", 32'(busy), 32'h0);
      @(posedge clk);
      #1;
      chk("rst_start_busy2", 32'(busy), 32'h0);
      chk("rst_start_rd", 32'(mem_rd_enb), 32'h0);

      // Reset while the second byte is on offer: byte dropped, no done.
      exp_addr.push_back(10'h008);
      exp_byte.push_back(8'h11);
      do_start(10'h008, 9'd2);
      @(posedge clk);
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("mid_second_byte", 32'(tx_data), 32'h22);
      rst      = 1'b1;
      tx_ready = 1'b0;
      @(posedge clk);
      #1;
      rst      = 1'b0;
      tx_ready = 1'b1;
      chk_outputs_zero("mid_rst");
      repeat (4) @(posedge clk);

      // A fresh dump after the abort behaves normally.
      push_word(10'h008, 32'h4433_2211);
      exp_lat.push_back(8);
      do_start(10'h008, 9'd1);
      wait_done(1'b0);

      n_vec++;
      if (exp_addr.size() != 0 || exp_byte.size() != 0 || exp_lat.size() != 0) begin
         n_bad++;
         $display("FAIL leftover: got %0d pending, required 0",
                  exp_addr.size() + exp_byte.size() + exp_lat.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
